// File: rtl/uart_cmd_responder.sv
// Knight-side UART endpoint: assembles 16-bit commands from two 8N1 bytes (high byte first)
// and serialises 8-bit response bytes back to the host. RX and TX paths are independent.
module uart_cmd_responder #(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int unsigned CntW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TmoMax = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TmoW   = $clog2(TmoMax + 1);

  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TmoMax);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic       {CmdWaitHi, CmdWaitLo}           cmd_state_e;
  typedef enum logic       {TxIdle, TxXmit}                 tx_state_e;

  // ---------------------------------------------------------------------------
  // RX synchroniser and start-edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic start_edge;

  // Two-flop synchroniser plus one delayed copy for edge detection; presets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bits_q, rx_bits_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_stb;
  logic            stop_bad;
  logic            frm_err_q;

  assign start_edge = (rx_state_q == RxIdle) && rx_prev_q && !rx_sync_q;

  // ---------------------------------------------------------------------------
  // RX byte engine
  // ---------------------------------------------------------------------------
  // RX state register, bit-time counter and data shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bits_q  <= '0;
      rx_shift_q <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
      frm_err_q  <= stop_bad;
    end
  end

  // RX next state: half-bit to the start sample, then one sample per bit time.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    byte_stb   = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (start_edge) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == BaudHalf) begin
          rx_cnt_d   = '0;
          rx_bits_d  = '0;
          // A high start sample is a line glitch, not a frame.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bits_d  = rx_bits_q + 3'd1;
          if (rx_bits_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BaudLast) begin
          // Back to idle mid stop bit so an immediately following start edge is caught.
          rx_state_d = RxIdle;
          if (rx_sync_q) byte_stb = 1'b1;
          else           stop_bad = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign frm_err = frm_err_q;

  // ---------------------------------------------------------------------------
  // Command assembly
  // ---------------------------------------------------------------------------
  cmd_state_e      cmd_state_q, cmd_state_d;
  logic [7:0]      hi_q, hi_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;

  // Command FSM state, held high byte, inter-byte timeout and output command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_state_q <= CmdWaitHi;
      hi_q        <= '0;
      tmo_q       <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      cmd_state_q <= cmd_state_d;
      hi_q        <= hi_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  // Command next state; the set of cmd_rdy is written last so it wins over any clear.
  always_comb begin
    cmd_state_d = cmd_state_q;
    hi_d        = hi_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (cmd_state_q)
      CmdWaitHi: begin
        tmo_d = '0;
        if (start_edge) cmd_rdy_d = 1'b0;
        if (byte_stb) begin
          hi_d        = rx_shift_q;
          cmd_state_d = CmdWaitLo;
        end
      end
      CmdWaitLo: begin
        if (byte_stb) begin
          cmd_d       = {hi_q, rx_shift_q};
          cmd_rdy_d   = 1'b1;
          cmd_state_d = CmdWaitHi;
        end else if (tmo_q == TmoLast) begin
          cmd_state_d = CmdWaitHi;
        end else if ((rx_state_q == RxIdle) && !start_edge) begin
          // Only line-idle time counts; the count freezes once a low byte starts.
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: cmd_state_d = CmdWaitHi;
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bits_q, tx_bits_d;
  logic            tx_done;

  // TX state, frame shift register (all ones when idle so TX rests high) and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
    end
  end

  // TX next state: load {stop, data, start}, shift one bit per bit time, ten bits in all.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d  = '0;
        tx_bits_d = '0;
        if (send_resp) begin
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_state_d = TxXmit;
        end
      end
      TxXmit: begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_bits_d  = tx_bits_q + 4'd1;
          if (tx_bits_q == 4'd9) begin
            tx_done    = 1'b1;
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign TX        = tx_shift_q[0];
  assign tx_busy   = (tx_state_q == TxXmit);
  assign resp_sent = tx_done;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder at BAUD_DIV=16, TIMEOUT_BITS=20.
module tb_uart_cmd_responder;

  localparam int unsigned BaudDiv     = 16;
  localparam int unsigned TimeoutBits = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;
  int sent_cnt = 0;

  uart_cmd_responder #(
    .BAUD_DIV    (BaudDiv),
    .TIMEOUT_BITS(TimeoutBits)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent),
    .tx_busy    (tx_busy),
    .frm_err    (frm_err)
  );

  always #5 clk = ~clk;

  // Pulse counters for the single-cycle strobes.
  always @(posedge clk) begin
    if (frm_err)   frm_cnt  <= frm_cnt + 1;
    if (resp_sent) sent_cnt <= sent_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop);
    RX = 1'b0;
    wait_cycles(BaudDiv);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      wait_cycles(BaudDiv);
    end
    RX = stop;
    wait_cycles(BaudDiv);
    RX = 1'b1;
  endtask

  task automatic pulse_clr;
    clr_cmd_rdy = 1'b1;
    wait_cycles(1);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX); end
    checks++;
    if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    checks++;
    if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++;
    if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent: got %b want 0", resp_sent); end
    checks++;
    if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    rst = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_cmd_basic;
    int bad;
    send_byte(8'h60, 1'b1);
    send_byte(8'h22, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy: got %b want 1", cmd_rdy); end
    checks++;
    if (cmd !== 16'h6022) begin errors++; $display("FAIL basic_cmd: got %h want 6022", cmd); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      wait_cycles(1);
      if (cmd_rdy !== 1'b1 || cmd !== 16'h6022) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_hold: %0d unstable cycles, want 0", bad); end
    pulse_clr();
    checks++;
    if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_clr: got %b want 0", cmd_rdy); end
    checks++;
    if (cmd !== 16'h6022) begin errors++; $display("FAIL basic_cmd_kept: got %h want 6022", cmd); end
    checks++;
    if (frm_cnt != 0) begin errors++; $display("FAIL basic_no_frm: got %0d pulses want 0", frm_cnt); end
  endtask

  task automatic test_tx_response;
    logic [9:0] frame;
    int         base;
    frame = {1'b1, 8'hA5, 1'b0};
    resp = 8'hA5;
    send_resp = 1'b1;
    wait_cycles(1);
    send_resp = 1'b0;
    base = sent_cnt;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BaudDiv; c++) begin
        checks++;
        if (TX !== frame[k]) begin
          errors++; $display("FAIL tx_bit%0d_c%0d: got %b want %b", k, c, TX, frame[k]);
        end
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++; $display("FAIL tx_busy_b%0d_c%0d: got %b want 1", k, c, tx_busy);
        end
        checks++;
        if (resp_sent !== ((k == 9) && (c == BaudDiv - 1))) begin
          errors++; $display("FAIL tx_resp_sent_b%0d_c%0d: got %b", k, c, resp_sent);
        end
        wait_cycles(1);
      end
    end
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b want 1", TX); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end: got %b want 0", tx_busy); end
    checks++;
    if (sent_cnt != base + 1) begin
      errors++; $display("FAIL tx_sent_once: got %0d want %0d", sent_cnt, base + 1);
    end
  endtask

  task automatic test_frame_error;
    int base;
    base = frm_cnt;
    send_byte(8'h5A, 1'b0);
    wait_cycles(4);
    checks++;
    if (frm_cnt != base + 1) begin
      errors++; $display("FAIL frm_pulse: got %0d want %0d", frm_cnt, base + 1);
    end
    checks++;
    if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL frm_no_rdy: got %b want 0", cmd_rdy); end
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++;
    if (cmd !== 16'h6000) begin errors++; $display("FAIL frm_cmd: got %h want 6000", cmd); end
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL frm_rdy: got %b want 1", cmd_rdy); end
    pulse_clr();
  endtask

  task automatic test_timeout;
    send_byte(8'h60, 1'b1);
    wait_cycles(400);
    send_byte(8'h12, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL tmo_hi_only: got %b want 0", cmd_rdy); end
    send_byte(8'h34, 1'b1);
    checks++;
    if (cmd !== 16'h1234) begin errors++; $display("FAIL tmo_cmd: got %h want 1234", cmd); end
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL tmo_rdy: got %b want 1", cmd_rdy); end
    pulse_clr();
    send_byte(8'h60, 1'b1);
    wait_cycles(300);
    send_byte(8'h12, 1'b1);
    checks++;
    if (cmd !== 16'h6012) begin errors++; $display("FAIL notmo_cmd: got %h want 6012", cmd); end
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL notmo_rdy: got %b want 1", cmd_rdy); end
    // cmd_rdy left set: the next command's start edge must clear it.
  endtask

  task automatic test_full_duplex;
    int         base;
    logic [9:0] frame;
    frame = {1'b1, 8'h5A, 1'b0};
    base = sent_cnt;
    fork
      begin
        send_byte(8'hC3, 1'b1);
        checks++;
        if (cmd_rdy !== 1'b0) begin
          errors++; $display("FAIL dup_start_clears_rdy: got %b want 0", cmd_rdy);
        end
        send_byte(8'h3C, 1'b1);
      end
      begin
        wait_cycles(40);
        resp = 8'h5A;
        send_resp = 1'b1;
        wait_cycles(1);
        send_resp = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < BaudDiv; c++) begin
            checks++;
            if (TX !== frame[k]) begin
              errors++; $display("FAIL dup_tx_b%0d_c%0d: got %b want %b", k, c, TX, frame[k]);
            end
            if (k == 4 && c == 0) begin
              resp = 8'h00;
              send_resp = 1'b1;
            end else begin
              send_resp = 1'b0;
            end
            wait_cycles(1);
          end
        end
        send_resp = 1'b0;
      end
    join
    checks++;
    if (cmd !== 16'hC33C) begin errors++; $display("FAIL dup_cmd: got %h want c33c", cmd); end
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL dup_rdy: got %b want 1", cmd_rdy); end
    wait_cycles(200);
    checks++;
    if (sent_cnt != base + 1) begin
      errors++; $display("FAIL dup_no_queue: got %0d sends want %0d", sent_cnt, base + 1);
    end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL dup_idle: got %b want 0", tx_busy); end
    pulse_clr();
  endtask

  task automatic test_reset_mid;
    logic [7:0] lo;
    int         bad;
    lo = 8'h22;
    send_byte(8'h11, 1'b1);
    RX = 1'b0;
    resp = 8'h81;
    send_resp = 1'b1;
    wait_cycles(1);
    send_resp = 1'b0;
    wait_cycles(BaudDiv - 1);
    for (int i = 0; i < 4; i++) begin
      RX = lo[i];
      wait_cycles(BaudDiv);
    end
    checks++;
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", tx_busy); end
    rst = 1'b1;
    RX = 1'b1;
    wait_cycles(1);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", TX); end
    checks++;
    if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b want 0", cmd_rdy); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
    checks++;
    if (cmd !== 16'h0000) begin errors++; $display("FAIL rstmid_cmd: got %h want 0000", cmd); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      wait_cycles(1);
      if (TX !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_tx_quiet: %0d active cycles want 0", bad); end
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++;
    if (cmd !== 16'h4000) begin errors++; $display("FAIL rstmid_cmd_after: got %h want 4000", cmd); end
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy_after: got %b want 1", cmd_rdy); end
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_tx_response();
    test_frame_error();
    test_timeout();
    test_full_duplex();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
